// File: rtl/instruction_fetch.sv
// IF stage of the TP4 MIPS pipeline: PC register, IF/ID latch, stall/redirect/HALT handling.
// Define IFETCH_STEP_EN to add step_mode/step_pulse single-step gating for the debug unit.
module instruction_fetch #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  MEM_DEPTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter logic [31:0]         HALT_WORD = 32'hFFFFFFFF
) (
  input  logic                clk,
  input  logic                rst,
`ifdef IFETCH_STEP_EN
  input  logic                step_mode,
  input  logic                step_pulse,
`endif
  input  logic                prog_mode,
  input  logic                stall,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_target,
  input  logic                jump,
  input  logic [PC_WIDTH-1:0] jump_target,
  input  logic [31:0]         imem_data,
  output logic [PC_WIDTH-1:0] imem_addr,
  output logic [31:0]         ifid_instr,
  output logic [PC_WIDTH-1:0] ifid_pc1,
  output logic                ifid_valid,
  output logic                halted,
  output logic [31:0]         instr_count
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [PC_WIDTH:0] DEPTH_W = (PC_WIDTH+1)'(MEM_DEPTH);
  localparam logic [PC_WIDTH:0] ONE_W   = {{PC_WIDTH{1'b0}}, 1'b1};

  state_t              state, next_state;
  logic [PC_WIDTH-1:0] pc, next_pc;
  logic [31:0]         next_instr;
  logic [PC_WIDTH-1:0] next_pc1;
  logic                next_valid;
  logic [31:0]         next_count;
  logic                freeze;
  logic                redirect;
  logic [PC_WIDTH-1:0] redirect_target;
  logic [PC_WIDTH-1:0] pc_plus1;

  // One extra bit so PC+1 at the top of the address space cannot overflow before the modulo.
  function automatic logic [PC_WIDTH-1:0] wrap_addr(input logic [PC_WIDTH:0] a);
    logic [PC_WIDTH:0] r;
    r = a % DEPTH_W;
    return r[PC_WIDTH-1:0];
  endfunction

`ifdef IFETCH_STEP_EN
  assign freeze = stall | (step_mode & ~step_pulse);
`else
  assign freeze = stall;
`endif

  assign redirect        = branch_taken | jump;
  assign redirect_target = branch_taken ? branch_target : jump_target;
  assign pc_plus1        = wrap_addr({1'b0, pc} + ONE_W);
  assign imem_addr       = pc;
  assign halted          = (state == HALT);

  always_comb begin
    next_state = state;
    next_pc    = pc;
    next_instr = ifid_instr;
    next_pc1   = ifid_pc1;
    next_valid = ifid_valid;
    next_count = instr_count;
    if (prog_mode) begin
      next_state = RUN;
      next_pc    = RESET_PC;
      next_instr = '0;
      next_pc1   = '0;
      next_valid = 1'b0;
      next_count = '0;
    end else if (redirect) begin
      // A HALT seen in the shadow of a redirect was speculative, so leave it.
      next_state = RUN;
      next_pc    = wrap_addr({1'b0, redirect_target});
      next_instr = '0;
      next_pc1   = '0;
      next_valid = 1'b0;
    end else if (state == HALT) begin
      next_instr = '0;
      next_pc1   = '0;
      next_valid = 1'b0;
    end else if (!freeze) begin
      next_instr = imem_data;
      next_pc1   = pc_plus1;
      next_valid = 1'b1;
      next_count = instr_count + 32'd1;
      if (imem_data == HALT_WORD) begin
        next_state = HALT;
      end else begin
        next_pc = pc_plus1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      pc          <= RESET_PC;
      ifid_instr  <= '0;
      ifid_pc1    <= '0;
      ifid_valid  <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= next_state;
      pc          <= next_pc;
      ifid_instr  <= next_instr;
      ifid_pc1    <= next_pc1;
      ifid_valid  <= next_valid;
      instr_count <= next_count;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed test-plan sequence, then randomized cycles
// checked against a behavioural fetch model.
module tb_instruction_fetch;

  localparam int          DEPTH = 32;
  localparam logic [31:0] HALTW = 32'hFFFFFFFF;

  logic        clk = 1'b0;
  logic        rst, prog_mode, stall, branch_taken, jump;
  logic [31:0] branch_target, jump_target, imem_data, imem_addr;
  logic [31:0] ifid_instr, ifid_pc1, instr_count;
  logic        ifid_valid, halted;
`ifdef IFETCH_STEP_EN
  logic        step_mode = 1'b0;
  logic        step_pulse = 1'b0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc1;
    logic [31:0] count;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem[DEPTH];
  int          checks = 0;
  int          errors = 0;

  int          mpc;
  logic [31:0] mcount, minstr, mpc1;
  bit          mhalt, mvalid;

  instruction_fetch dut (
    .clk(clk), .rst(rst),
`ifdef IFETCH_STEP_EN
    .step_mode(step_mode), .step_pulse(step_pulse),
`endif
    .prog_mode(prog_mode), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target),
    .imem_data(imem_data), .imem_addr(imem_addr),
    .ifid_instr(ifid_instr), .ifid_pc1(ifid_pc1), .ifid_valid(ifid_valid),
    .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous read on the falling edge.
  always @(negedge clk) imem_data <= mem[imem_addr % DEPTH];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input bit r, input bit pm, input bit st, input bit br,
                               input int bt, input bit jp, input int jt);
    exp_t e;
    bit   frz;
    @(negedge clk);
    rst = r; prog_mode = pm; stall = st;
    branch_taken = br; branch_target = bt; jump = jp; jump_target = jt;
    frz = st;
`ifdef IFETCH_STEP_EN
    frz = st | (step_mode & ~step_pulse);
`endif
    if (r || pm) begin
      mpc = 0; mhalt = 0; mcount = 0; minstr = 0; mpc1 = 0; mvalid = 0;
    end else if (br || jp) begin
      mpc = (br ? bt : jt) % DEPTH; mhalt = 0; minstr = 0; mpc1 = 0; mvalid = 0;
    end else if (mhalt) begin
      minstr = 0; mpc1 = 0; mvalid = 0;
    end else if (!frz) begin
      minstr = mem[mpc]; mvalid = 1; mpc1 = (mpc + 1) % DEPTH; mcount = mcount + 1;
      if (minstr == HALTW) mhalt = 1;
      else mpc = (mpc + 1) % DEPTH;
    end
    e.pc = mpc; e.instr = minstr; e.pc1 = mpc1; e.count = mcount;
    e.valid = mvalid; e.halted = mhalt;
    sb.push_back(e);
  endtask

  task automatic seq(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: the DUT presents a new IF/ID state every edge; compare it to the oldest prediction.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checkOutput("imem_addr", imem_addr, e.pc);
      checkOutput("ifid_valid", {31'b0, ifid_valid}, {31'b0, e.valid});
      checkOutput("ifid_instr", ifid_instr, e.instr);
      if (e.valid) checkOutput("ifid_pc1", ifid_pc1, e.pc1);
      checkOutput("halted", {31'b0, halted}, {31'b0, e.halted});
      checkOutput("instr_count", instr_count, e.count);
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = $urandom();
      if (mem[i] == HALTW) mem[i] = 32'h0000_0001;
    end
    mem[0] = 32'h20010008; mem[1] = 32'h20020003;
    mem[2] = 32'h20060001; mem[3] = 32'h2009000E;
    mem[6] = HALTW;        mem[25] = HALTW;
    rst = 1; prog_mode = 0; stall = 0; branch_taken = 0; jump = 0;
    branch_target = 0; jump_target = 0;
    mpc = 0; mcount = 0; minstr = 0; mpc1 = 0; mhalt = 0; mvalid = 0;

    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0);
    seq(2);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 1, 0, 0, 0, 0);
    seq(2);
    applyStimulus(0, 0, 1, 1, 17, 1, 5);
    seq(2);
    applyStimulus(0, 0, 0, 0, 0, 1, 4);
    seq(5);
    applyStimulus(0, 0, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 2, 0, 0);
    seq(2);
    applyStimulus(0, 0, 0, 0, 0, 1, 30);
    seq(3);
    applyStimulus(0, 0, 0, 0, 0, 1, 9);
    seq(1);
    applyStimulus(0, 1, 0, 0, 0, 0, 0);
    seq(2);
    applyStimulus(0, 0, 0, 1, 63, 0, 0);
    seq(2);

    for (int i = 0; i < 600; i++) begin
`ifdef IFETCH_STEP_EN
      step_mode  = ($urandom_range(0, 3) == 0);
      step_pulse = $urandom_range(0, 1);
`endif
      applyStimulus($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 25,
                    $urandom_range(0, 99) < 6, $urandom_range(0, 63),
                    $urandom_range(0, 99) < 6, $urandom_range(0, 63));
    end

    @(posedge clk);
    #2;
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
